// File: rtl/id_alloc_pkg.sv
// Shared constants and helpers for the free-list ID allocator and its scanner.
package id_alloc_pkg;

  // Default pool sizes for the core's tagged resources
  localparam int unsigned ROB_NUM_ID  = 32;
  localparam int unsigned MSHR_NUM_ID = 8;
  localparam int unsigned SB_NUM_ID   = 16;

  localparam bit LZC_TRAILING = 1'b0;
  localparam bit LZC_LEADING  = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_alloc_lzc.sv
// Zero counter: MODE 0 gives the index of the lowest set bit, MODE 1 the leading-zero count.
// An all-zero input reports WIDTH-1 together with empty_o.
module lzc
  import id_alloc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MODE      = LZC_TRAILING,
  parameter int unsigned CNT_WIDTH = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  assign empty_o = ~|in_i;

  generate
    if (MODE == LZC_TRAILING) begin : g_trailing
      // Scan downwards so the lowest set bit is the last one to win
      always_comb begin
        cnt_o = CNT_WIDTH'(WIDTH - 1);
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (in_i[i]) cnt_o = CNT_WIDTH'(i);
        end
      end
    end else begin : g_leading
      always_comb begin
        cnt_o = CNT_WIDTH'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
          if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/id_alloc.sv
// Free-list ID allocator: offers the lowest free ID each cycle, takes IDs back through
// a release port, and latches a sticky error on double or out-of-range frees.
module id_alloc
  import id_alloc_pkg::*;
#(
  parameter int unsigned NUM_ID    = 8,
  parameter int unsigned ID_WIDTH  = idx_width(NUM_ID),
  parameter int unsigned CNT_WIDTH = $clog2(NUM_ID + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  output logic                 alloc_valid_o,
  output logic [ID_WIDTH-1:0]  alloc_id_o,
  input  logic                 alloc_ready_i,
  input  logic                 free_valid_i,
  input  logic [ID_WIDTH-1:0]  free_id_i,
  output logic [CNT_WIDTH-1:0] free_cnt_o,
  output logic                 err_o
);

  typedef logic [ID_WIDTH-1:0] id_t;

  localparam logic [ID_WIDTH:0] NUM_ID_EXT = (ID_WIDTH + 1)'(NUM_ID);

  logic [NUM_ID-1:0]    r_free;
  logic [NUM_ID-1:0]    w_free_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 r_err;
  id_t                  w_lzc_id;
  logic                 w_empty;
  logic                 w_alloc_fire;
  logic                 w_free_in_range;
  logic                 w_free_fire;
  logic                 w_free_bad;

  lzc #(
    .WIDTH    (NUM_ID),
    .MODE     (LZC_TRAILING),
    .CNT_WIDTH(ID_WIDTH)
  ) u_lzc (
    .in_i   (r_free),
    .cnt_o  (w_lzc_id),
    .empty_o(w_empty)
  );

  assign alloc_valid_o = ~w_empty;
  assign alloc_id_o    = w_lzc_id;
  assign free_cnt_o    = r_cnt;
  assign err_o         = r_err;

  assign w_alloc_fire    = ~w_empty & alloc_ready_i;
  assign w_free_in_range = {1'b0, free_id_i} < NUM_ID_EXT;
  // A free of the ID being offered sees its bit set, so it lands here as a double free
  assign w_free_fire     = free_valid_i & w_free_in_range & ~r_free[free_id_i];
  assign w_free_bad      = free_valid_i & ~w_free_fire;

  generate
    for (genvar gi = 0; gi < NUM_ID; gi++) begin : g_bit
      assign w_free_next[gi] = (r_free[gi] & ~(w_alloc_fire & (w_lzc_id == id_t'(gi))))
                             | (w_free_fire & (free_id_i == id_t'(gi)));
    end
  endgenerate

  assign w_cnt_next = r_cnt - CNT_WIDTH'(w_alloc_fire) + CNT_WIDTH'(w_free_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_free <= '1;
      r_cnt  <= CNT_WIDTH'(NUM_ID);
      r_err  <= 1'b0;
    end else if (flush_i) begin
      r_free <= '1;
      r_cnt  <= CNT_WIDTH'(NUM_ID);
    end else begin
      r_free <= w_free_next;
      r_cnt  <= w_cnt_next;
      if (w_free_bad) r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (NUM_ID >= 2);
    if (!rst) assert (r_cnt == CNT_WIDTH'($countones(r_free)));
  end
`endif

endmodule

// File: tb/tb_id_alloc.sv
// Scoreboard bench for id_alloc: a set-based model predicts the post-edge outputs,
// a monitor compares them one edge later.
module tb_id_alloc;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, flush = 1'b0, ready = 1'b0, fv = 1'b0;
  logic [IW-1:0] fid = '0;
  logic          avalid;
  logic [IW-1:0] aid;
  logic [CW-1:0] fcnt;
  logic          err;

  // Second instance with a non-power-of-two pool so an out-of-range ID is expressible
  logic       f6v = 1'b0;
  logic [2:0] f6id = '0;
  logic       a6v, e6;
  logic [2:0] a6id, c6;

  id_alloc #(.NUM_ID(N)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .alloc_valid_o(avalid), .alloc_id_o(aid), .alloc_ready_i(ready),
    .free_valid_i(fv), .free_id_i(fid), .free_cnt_o(fcnt), .err_o(err)
  );

  id_alloc #(.NUM_ID(6)) u_dut6 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .alloc_valid_o(a6v), .alloc_id_o(a6id), .alloc_ready_i(1'b0),
    .free_valid_i(f6v), .free_id_i(f6id), .free_cnt_o(c6), .err_o(e6)
  );

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
    logic [CW-1:0] cnt;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   m_free[N];
  bit   m_err = 1'b0;

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic int count_free();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_free[i]) c++;
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the coming edge
  task automatic step(input bit r, input bit fl, input bit rd, input bit v, input int id);
    int   lo;
    bit   fire, ok;
    exp_t e;
    @(negedge clk);
    rst = r; flush = fl; ready = rd; fv = v; fid = id[IW-1:0];
    lo = lowest_free();
    if (r || fl) begin
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
      if (r) m_err = 1'b0;
    end else begin
      fire = rd && (lo >= 0);
      ok   = v && (id < N) && !m_free[id];
      if (fire) m_free[lo] = 1'b0;
      if (v && !ok) m_err = 1'b1;
      if (ok) m_free[id] = 1'b1;
    end
    lo      = lowest_free();
    e.valid = (lo >= 0);
    e.id    = (lo >= 0) ? IW'(lo) : IW'(N - 1);
    e.cnt   = CW'(count_free());
    e.err   = m_err;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (avalid !== e.valid) begin
          miscompares++;
          $display("FAIL alloc_valid: got %b expected %b at %0t", avalid, e.valid, $time);
        end
        if (aid !== e.id) begin
          miscompares++;
          $display("FAIL alloc_id: got %0d expected %0d at %0t", aid, e.id, $time);
        end
        if (fcnt !== e.cnt) begin
          miscompares++;
          $display("FAIL free_cnt: got %0d expected %0d at %0t", fcnt, e.cnt, $time);
        end
        if (err !== e.err) begin
          miscompares++;
          $display("FAIL err: got %b expected %b at %0t", err, e.err, $time);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "timeout");
  end

  initial begin : driver
    int outs[$];
    int pick;
    bit r, fl, rd, v;

    step(1, 0, 0, 0, 0);

    // Full allocation in order, then ready while empty
    step(0, 0, 1, 0, 0);
    chk("dut6_reset_err", int'(e6), 0);
    chk("dut6_reset_cnt", int'(c6), 6);
    f6v = 1'b1; f6id = 3'd7;
    step(0, 0, 1, 0, 0);
    f6v = 1'b0;
    chk("dut6_range_err", int'(e6), 1);
    chk("dut6_range_cnt", int'(c6), 6);
    repeat (6) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("dut6_err_sticky", int'(e6), 1);
    chk("dut6_offer", int'(a6id), 0);

    // Release 5 from a full pool
    step(0, 0, 0, 1, 5);
    step(0, 0, 0, 0, 0);

    // Alloc 0..3, then alloc 4 while releasing 2
    step(0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 2);

    // Double free of a free ID, then flush with 5 outstanding and a concurrent free
    step(0, 0, 0, 1, 6);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0);

    // Free of the ID being offered in the same cycle it is allocated
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);

    for (int n = 0; n < 10000; n++) begin
      r  = ($urandom_range(0, 1999) == 0);
      fl = ($urandom_range(0, 499) == 0);
      rd = ($urandom_range(0, 9) < 7);
      v  = ($urandom_range(0, 1) == 1);
      outs.delete();
      for (int i = 0; i < N; i++) if (!m_free[i]) outs.push_back(i);
      if (outs.size() > 0 && $urandom_range(0, 9) < 7)
        pick = outs[$urandom_range(0, outs.size() - 1)];
      else
        pick = $urandom_range(0, N - 1);
      step(r, fl, rd, v, pick);
    end

    step(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
